// File: rtl/convex_hull_accel_mul_pipe.sv
// convex_hull_accel_mul_pipe: valid/ready pipelined multiplier with per-beat operand signedness.
// Build macro MUL_SATURATE_EN clamps out_p on overflow; otherwise the product is truncated.
module convex_hull_accel_mul_pipe #(
  parameter int ID         = 1,
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 16,
  parameter int DOUT_WIDTH = 32,
  parameter int NUM_STAGE  = 3
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] in_a,
  input  logic [DIN1_WIDTH-1:0] in_b,
  input  logic                  in_a_sgn,
  input  logic                  in_b_sgn,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] out_p,
  output logic                  out_ovf,
  output logic                  busy
);

  localparam int FW = DIN0_WIDTH + DIN1_WIDTH;
  localparam int id_unused = ID;

  logic [NUM_STAGE-1:0] valid_q;
  logic [NUM_STAGE-1:0] sgn_q;
  logic signed [FW:0]   prod_q [NUM_STAGE];
  logic [NUM_STAGE:0]   ready;

  logic signed [FW:0] a_ext, b_ext, prod_d;
  logic signed [FW:0] prod_last;
  logic               sgn_last;
  logic               ovf;

  // One extra bit lets unsigned x unsigned and mixed-sign products share a signed multiply.
  always_comb begin
    a_ext  = {{(FW+1-DIN0_WIDTH){in_a_sgn & in_a[DIN0_WIDTH-1]}}, in_a};
    b_ext  = {{(FW+1-DIN1_WIDTH){in_b_sgn & in_b[DIN1_WIDTH-1]}}, in_b};
    prod_d = a_ext * b_ext;
  end

  always_comb begin
    ready = '0;
    ready[NUM_STAGE] = out_ready;
    for (int k = NUM_STAGE - 1; k >= 0; k--) begin
      ready[k] = !valid_q[k] | ready[k+1];
    end
  end

  // Data only moves with a valid beat, so out_p holds its last value across bubbles.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      valid_q <= '0;
      sgn_q   <= '0;
      for (int k = 0; k < NUM_STAGE; k++) prod_q[k] <= '0;
    end else begin
      if (ready[0]) begin
        valid_q[0] <= in_valid;
        if (in_valid) begin
          prod_q[0] <= prod_d;
          sgn_q[0]  <= in_a_sgn | in_b_sgn;
        end
      end
      for (int k = 1; k < NUM_STAGE; k++) begin
        if (ready[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) begin
            prod_q[k] <= prod_q[k-1];
            sgn_q[k]  <= sgn_q[k-1];
          end
        end
      end
    end
  end

  assign prod_last = prod_q[NUM_STAGE-1];
  assign sgn_last  = sgn_q[NUM_STAGE-1];

  always_comb begin
    ovf = 1'b0;
    for (int i = DOUT_WIDTH; i <= FW; i++) begin
      if (sgn_last ? (prod_last[i] != prod_last[DOUT_WIDTH-1]) : prod_last[i]) ovf = 1'b1;
    end
  end

  always_comb begin
    out_p = prod_last[DOUT_WIDTH-1:0];
`ifdef MUL_SATURATE_EN
    if (ovf) begin
      if (!sgn_last)         out_p = '1;
      else if (prod_last[FW]) out_p = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
      else                   out_p = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
    end
`else
`endif
  end

  assign out_ovf   = ovf;
  assign out_valid = valid_q[NUM_STAGE-1];
  assign in_ready  = ready[0];
  assign busy      = |valid_q;

endmodule

// File: tb/tb_convex_hull_accel_mul_pipe.sv
// Directed and randomised checks of convex_hull_accel_mul_pipe: 16x16->32 (3 stages) and 8x8->8 (1 stage).
module tb_convex_hull_accel_mul_pipe;

`ifdef MUL_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic ap_clk = 1'b0;
  logic ap_rst_n;
  always #5 ap_clk = ~ap_clk;

  logic        a_in_valid, a_in_ready, a_in_a_sgn, a_in_b_sgn;
  logic        a_out_valid, a_out_ready, a_out_ovf, a_busy;
  logic [15:0] a_in_a, a_in_b;
  logic [31:0] a_out_p;

  logic        b_in_valid, b_in_ready, b_in_a_sgn, b_in_b_sgn;
  logic        b_out_valid, b_out_ready, b_out_ovf, b_busy;
  logic [7:0]  b_in_a, b_in_b, b_out_p;

  convex_hull_accel_mul_pipe #(.ID(1), .DIN0_WIDTH(16), .DIN1_WIDTH(16), .DOUT_WIDTH(32), .NUM_STAGE(3)) u_dut_a (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_a(a_in_a), .in_b(a_in_b),
    .in_a_sgn(a_in_a_sgn), .in_b_sgn(a_in_b_sgn),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_p(a_out_p), .out_ovf(a_out_ovf), .busy(a_busy)
  );

  convex_hull_accel_mul_pipe #(.ID(2), .DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(8), .NUM_STAGE(1)) u_dut_b (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_a(b_in_a), .in_b(b_in_b),
    .in_a_sgn(b_in_a_sgn), .in_b_sgn(b_in_b_sgn),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_p(b_out_p), .out_ovf(b_out_ovf), .busy(b_busy)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] expq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic sa, input logic sb);
    longint ea, eb, p;
    ea = sa ? longint'(signed'(a)) : longint'(a);
    eb = sb ? longint'(signed'(b)) : longint'(b);
    p  = ea * eb;
    return p[31:0];
  endfunction

  task automatic beat_a(input logic [15:0] a, input logic [15:0] b, input logic sa, input logic sb,
                        input logic [31:0] exp_p, input string tag);
    int lat;
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_in_a = a; a_in_b = b; a_in_a_sgn = sa; a_in_b_sgn = sb;
    #1;
    check({tag, "_in_ready"}, a_in_ready, 1);
    tick;
    a_in_valid = 1'b0; a_in_a = '0; a_in_b = '0;
    lat = 1;
    while (!a_out_valid && lat < 20) begin
      tick;
      lat++;
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_p"}, a_out_p, exp_p);
    check({tag, "_ovf"}, a_out_ovf, 0);
    tick;
    check({tag, "_drained"}, a_out_valid, 0);
  endtask

  task automatic beat_b(input logic [7:0] a, input logic [7:0] b, input logic sa, input logic sb,
                        input logic [7:0] exp_p, input logic exp_ovf, input string tag);
    int lat;
    b_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_a = a; b_in_b = b; b_in_a_sgn = sa; b_in_b_sgn = sb;
    #1;
    tick;
    b_in_valid = 1'b0;
    lat = 1;
    while (!b_out_valid && lat < 20) begin
      tick;
      lat++;
    end
    check({tag, "_latency"}, lat, 1);
    check({tag, "_p"}, b_out_p, exp_p);
    check({tag, "_ovf"}, b_out_ovf, exp_ovf);
    tick;
  endtask

  initial begin
    int idx, rcv, cyc, seen;
    logic prev_stall;
    logic [31:0] prev_p;

    ap_rst_n = 1'b0;
    a_in_valid = 0; a_in_a = 0; a_in_b = 0; a_in_a_sgn = 0; a_in_b_sgn = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_a = 0; b_in_b = 0; b_in_a_sgn = 0; b_in_b_sgn = 0; b_out_ready = 1;
    repeat (3) tick;
    ap_rst_n = 1'b1;
    tick;
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_p", a_out_p, 0);
    check("rst_out_ovf", a_out_ovf, 0);
    check("rst_busy", a_busy, 0);
    check("rst_in_ready", a_in_ready, 1);
    check("rst_b_in_ready", b_in_ready, 1);

    beat_a(16'hFFFF, 16'hFFFF, 0, 0, 32'hFFFE0001, "uns_max");
    beat_a(16'hFF80, 16'hFF80, 1, 1, 32'h00004000, "sgn_neg_neg");
    beat_a(16'hFFFF, 16'h0001, 1, 0, 32'hFFFFFFFF, "mixed_m1");
    beat_a(16'h7FFF, 16'h8000, 1, 1, 32'hC0008000, "sgn_extreme");
    beat_a(16'h1234, 16'h0010, 0, 0, 32'h00012340, "uns_small");

    beat_b(8'd16, 8'd16, 0, 0, SAT ? 8'hFF : 8'h00, 1, "b_uns_ovf");
    beat_b(8'd15, 8'd17, 0, 0, 8'hFF, 0, "b_uns_fit");
    beat_b(8'hFF, 8'hFF, 1, 1, 8'h01, 0, "b_sgn_m1m1");
    beat_b(8'h80, 8'h01, 1, 0, 8'h80, 0, "b_mixed_min");
    beat_b(8'h40, 8'h02, 1, 1, SAT ? 8'h7F : 8'h80, 1, "b_sgn_pos_ovf");
    beat_b(8'h80, 8'h02, 1, 1, SAT ? 8'h80 : 8'h00, 1, "b_sgn_neg_ovf");
    beat_b(8'hFF, 8'hFF, 0, 1, SAT ? 8'h80 : 8'h01, 1, "b_mixed_neg_ovf");

    // back-pressure: 5 beats offered against a stalled sink
    a_out_ready = 1'b0; idx = 0; rcv = 0; expq.delete();
    for (int c = 0; c < 6; c++) begin
      a_in_valid = (idx < 5); a_in_a = 16'(idx + 1); a_in_b = 16'd3; a_in_a_sgn = 0; a_in_b_sgn = 0;
      #1;
      if (a_in_valid && a_in_ready) begin
        expq.push_back(32'((idx + 1) * 3));
        idx++;
      end
      tick;
    end
    #1;
    check("bp_accepted", idx, 3);
    check("bp_in_ready", a_in_ready, 0);
    check("bp_busy", a_busy, 1);
    check("bp_out_valid", a_out_valid, 1);
    check("bp_held_p", a_out_p, 3);
    a_out_ready = 1'b1;
    for (int c = 0; c < 20 && rcv < 5; c++) begin
      a_in_valid = (idx < 5); a_in_a = 16'(idx + 1); a_in_b = 16'd3;
      #1;
      if (a_out_valid) begin
        check("bp_data", a_out_p, (expq.size() > 0) ? expq.pop_front() : 32'hDEAD_BEEF);
        rcv++;
      end
      if (a_in_valid && a_in_ready) begin
        expq.push_back(32'((idx + 1) * 3));
        idx++;
      end
      tick;
    end
    a_in_valid = 1'b0;
    check("bp_received", rcv, 5);
    check("bp_all_accepted", idx, 5);

    // random valid/ready toggling with a reference product model
    idx = 0; rcv = 0; cyc = 0; prev_stall = 0; prev_p = '0; expq.delete();
    while (rcv < 300 && cyc < 4000) begin
      a_in_valid  = (idx < 300) && ($urandom_range(0, 9) < 7);
      a_out_ready = ($urandom_range(0, 9) < 6);
      a_in_a = 16'($urandom); a_in_b = 16'($urandom);
      a_in_a_sgn = 1'($urandom); a_in_b_sgn = 1'($urandom);
      #1;
      if (prev_stall) begin
        check("rnd_stall_valid", a_out_valid, 1);
        check("rnd_stall_p", a_out_p, prev_p);
      end
      if (a_out_valid && a_out_ready) begin
        check("rnd_p", a_out_p, (expq.size() > 0) ? expq.pop_front() : 32'hDEAD_BEEF);
        check("rnd_ovf", a_out_ovf, 0);
        rcv++;
      end
      if (a_in_valid && a_in_ready) begin
        expq.push_back(ref_mul(a_in_a, a_in_b, a_in_a_sgn, a_in_b_sgn));
        idx++;
      end
      prev_stall = a_out_valid && !a_out_ready;
      prev_p = a_out_p;
      tick;
      cyc++;
    end
    a_in_valid = 1'b0;
    check("rnd_received", rcv, 300);
    check("rnd_queue_empty", expq.size(), 0);

    // reset with two beats in flight
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_a = 16'd7; a_in_b = 16'd9; a_in_a_sgn = 0; a_in_b_sgn = 0;
    tick;
    tick;
    a_in_valid = 1'b0;
    check("inflight_busy", a_busy, 1);
    ap_rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", a_out_valid, 0);
    check("rst_mid_busy", a_busy, 0);
    tick;
    ap_rst_n = 1'b1;
    a_out_ready = 1'b1;
    #1;
    check("rst_mid_in_ready", a_in_ready, 1);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (a_out_valid) seen++;
    end
    check("rst_mid_no_stale", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
